// File: rtl/rgb_pkg.sv
// Shared constants and state type for the WS2812b pixel scheduler.
package rgb_pkg;

   localparam int BITS_PER_PIXEL = 24;
   localparam int PIXEL_W        = 24;

   // Byte lanes of the GRB word as it arrives on the wire, MSB first.
   localparam int G_MSB = 23;
   localparam int R_MSB = 15;
   localparam int B_MSB = 7;

   typedef enum logic [1:0] {
      SYNC,
      RECV,
      DROP
   } state_t;

   function automatic logic [PIXEL_W-1:0] grb_to_rgb(input logic [PIXEL_W-1:0] w);
      return {w[R_MSB -: 8], w[G_MSB -: 8], w[B_MSB -: 8]};
   endfunction

endpackage

// File: rtl/pix_fifo.sv
// Show-ahead pixel FIFO: the head entry is always presented on dout from the storage flops.
module pix_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/rgb_pixel_sched.sv
// Frame-level controller: assembles decoded GRB bits into numbered RGB pixels and queues them downstream.
//
// state | meaning
// SYNC  | waiting for first stream reset; data bits discarded
// RECV  | assembling pixels and pushing them into the FIFO
// DROP  | frame already has NUM_LEDS pixels; bits only counted
module rgb_pixel_sched
   import rgb_pkg::*;
#(
   parameter  int NUM_LEDS   = 64,
   parameter  int FIFO_DEPTH = 4,
   localparam int IDX_W      = $clog2(NUM_LEDS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bit_val,
   input  logic               bit_strobe,
   input  logic               bit_reset,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [PIXEL_W-1:0] pix_rgb,
   output logic [IDX_W-1:0]   pix_idx,
   output logic               frame_done,
   output logic [IDX_W:0]     frame_len,
   output logic               frame_partial,
   output logic               overflow,
   input  logic               clr_overflow,
   output logic               synced
);

   localparam int             ENTRY_W  = PIXEL_W + IDX_W;
   localparam logic [IDX_W:0] LED_MAX  = (IDX_W+1)'(NUM_LEDS);
   localparam logic [4:0]     LAST_BIT = 5'(BITS_PER_PIXEL - 1);

   state_t               state_q, state_d;
   logic [PIXEL_W-2:0]   sh_q, sh_d;
   logic [4:0]           bitcnt_q, bitcnt_d;
   logic [IDX_W:0]       px_cnt_q, px_cnt_d;
   logic                 frame_done_q, frame_done_d;
   logic [IDX_W:0]       frame_len_q, frame_len_d;
   logic                 frame_partial_q, frame_partial_d;
   logic                 overflow_q, overflow_d;

   logic                 rst_ev;
   logic                 data_ev;
   logic                 last_bit;
   logic [PIXEL_W-1:0]   word_nx;
   logic [IDX_W:0]       px_inc;
   logic                 push_req;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [ENTRY_W-1:0]   fifo_din;
   logic [ENTRY_W-1:0]   fifo_dout;

   assign rst_ev   = bit_strobe & bit_reset;
   assign data_ev  = bit_strobe & ~bit_reset;
   assign last_bit = (bitcnt_q == LAST_BIT);
   assign word_nx  = {sh_q, bit_val};
   assign px_inc   = px_cnt_q + (IDX_W+1)'(1);
   assign fifo_din = {grb_to_rgb(word_nx), px_cnt_q[IDX_W-1:0]};

   always_comb begin
      state_d         = state_q;
      sh_d            = sh_q;
      bitcnt_d        = bitcnt_q;
      px_cnt_d        = px_cnt_q;
      frame_done_d    = 1'b0;
      frame_len_d     = frame_len_q;
      frame_partial_d = frame_partial_q;
      push_req        = 1'b0;
      case (state_q)
         SYNC: begin
            if (rst_ev) begin
               state_d  = RECV;
               bitcnt_d = '0;
               px_cnt_d = '0;
            end
         end
         RECV, DROP: begin
            if (rst_ev) begin
               frame_done_d    = 1'b1;
               frame_len_d     = px_cnt_q;
               frame_partial_d = (bitcnt_q != 5'd0);
               px_cnt_d        = '0;
               bitcnt_d        = '0;
               state_d         = RECV;
            end else if (data_ev) begin
               bitcnt_d = last_bit ? 5'd0 : bitcnt_q + 5'd1;
               if (state_q == RECV) begin
                  sh_d = word_nx[PIXEL_W-2:0];
                  if (last_bit) begin
                     push_req = 1'b1;
                     px_cnt_d = px_inc;
                     if (px_inc == LED_MAX) begin
                        state_d = DROP;
                     end
                  end
               end
            end
         end
         default: state_d = SYNC;
      endcase

      // A full FIFO only accepts the push when the head is popped in the same cycle.
      overflow_d = overflow_q;
      if (clr_overflow) begin
         overflow_d = 1'b0;
      end
      if (push_req & fifo_full & ~pix_ready) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= SYNC;
         sh_q            <= '0;
         bitcnt_q        <= '0;
         px_cnt_q        <= '0;
         frame_done_q    <= 1'b0;
         frame_len_q     <= '0;
         frame_partial_q <= 1'b0;
         overflow_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         sh_q            <= sh_d;
         bitcnt_q        <= bitcnt_d;
         px_cnt_q        <= px_cnt_d;
         frame_done_q    <= frame_done_d;
         frame_len_q     <= frame_len_d;
         frame_partial_q <= frame_partial_d;
         overflow_q      <= overflow_d;
      end
   end

   pix_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .din   (fifo_din),
      .full  (fifo_full),
      .pop   (pix_ready),
      .empty (fifo_empty),
      .dout  (fifo_dout)
   );

   assign pix_valid     = ~fifo_empty;
   assign pix_rgb       = fifo_dout[ENTRY_W-1 -: PIXEL_W];
   assign pix_idx       = fifo_dout[IDX_W-1:0];
   assign frame_done    = frame_done_q;
   assign frame_len     = frame_len_q;
   assign frame_partial = frame_partial_q;
   assign overflow      = overflow_q;
   assign synced        = (state_q != SYNC);

endmodule

// File: doc/rgb_pixel_sched.md
# rgb_pixel_sched

Frame-level controller behind the WS2812b serial-bit decoder. Consumes the decoder's bit/strobe/stream-reset outputs and assembles 24-bit GRB words into RGB pixels, numbering each pixel within the frame. It buffers the pixels in a small FIFO and hands them to the downstream RGB→RGBW converter over a valid/ready handshake. It also tracks frame boundaries, frame length and error conditions.

## Interface
- NUM_LEDS, 64: pixels accepted per frame; later pixels are dropped.
- FIFO_DEPTH, 4: pixel FIFO entries; power of 2, ≥2.
- IDX_W (localparam), $clog2(NUM_LEDS): pixel index width.

- clk  in  1  system clock, 96 MHz
- rst  in  1  reset, asynchronous, active-high
- bit_val  in  1  decoded bit value; meaningful when bit_strobe=1 and bit_reset=0
- bit_strobe  in  1  one-cycle strobe from the decoder
- bit_reset  in  1  stream-reset qualifier, valid with bit_strobe
- pix_valid  out  1  FIFO head holds a pixel
- pix_ready  in  1  downstream accepts the head pixel
- pix_rgb  out  24  {R,G,B}, 8 bits each
- pix_idx  out  IDX_W  pixel position in the frame, 0-based
- frame_done  out  1  one-cycle pulse at the end of a frame
- frame_len  out  IDX_W+1  complete pixels in the last frame, saturating at NUM_LEDS
- frame_partial  out  1  last frame ended with 1–23 stray bits
- overflow  out  1  sticky; a pixel was lost because the FIFO was full
- clr_overflow  in  1  synchronous clear of overflow
- synced  out  1  high when not in SYNC state

## Operation
- Events: stream reset = bit_strobe & bit_reset. Data bit = bit_strobe & ~bit_reset. Cycles without a strobe are ignored.
- FSM states:
  - SYNC: entered on reset. Data bits are discarded. A stream reset moves to RECV and does not pulse frame_done.
  - RECV: data bits shift MSB-first into a 24-bit register, and a 5-bit bit counter counts 0..23. On the 24th bit the pixel {R,G,B} = {w[15:8], w[23:16], w[7:0]} is pushed to the FIFO with pix_idx = px_cnt. px_cnt then increments and the bit counter returns to 0. When px_cnt reaches NUM_LEDS the FSM moves to DROP.
  - DROP: data bits are counted for frame_partial only. No pushes are made and px_cnt holds at NUM_LEDS.
- A stream reset in RECV or DROP does the following:
  - pulses frame_done;
  - loads frame_len ← px_cnt and frame_partial ← (bitcnt≠0);
  - discards the partial word;
  - clears px_cnt and bitcnt;
  - goes to RECV.
- FIFO push when full with no pop in the same cycle: the pixel is lost and overflow is set. px_cnt still increments.
- FIFO push when full with a pop in the same cycle: the push is accepted.
- Pop happens when pix_valid & pix_ready. pix_rgb and pix_idx are stable while pix_valid=1 and pix_ready=0.
- overflow is set on a drop and cleared by clr_overflow. If both occur in the same cycle, set wins.
- Widths: bitcnt is 5 bits. px_cnt is IDX_W+1 bits and saturates at NUM_LEDS. FIFO pointers are $clog2(FIFO_DEPTH)+1 bits with wrap.

## Timing
- Reset values:
  - outputs: pix_valid=0, pix_rgb=0, pix_idx=0, frame_done=0, frame_len=0, frame_partial=0, overflow=0, synced=0;
  - internal: state=SYNC, FIFO empty.
- Bit strobes arrive at least 100 clocks apart. The block must still be correct with back-to-back strobes.
- Latency: a 24th-bit strobe in cycle N gives pix_valid=1 in cycle N+1 if the FIFO was empty. The FIFO is show-ahead, with a registered head.
- frame_done is high for exactly cycle N+1 after the stream-reset strobe in cycle N. frame_len and frame_partial update in that same cycle and hold until the next frame_done.
- synced rises in cycle N+1 after the first stream reset.
- rst asserted mid-frame clears everything immediately, including FIFO contents. The block then returns to SYNC.
- pix_ready is honoured in any cycle, including the push cycle.

## Structure
- Shared package rgb_pkg:
  - BITS_PER_PIXEL=24 and PIXEL_W=24;
  - byte-lane constants G_MSB/R_MSB/B_MSB;
  - state enum {SYNC, RECV, DROP}.
- Sub-module pix_fifo: synchronous show-ahead FIFO with async reset.
  - Parameters WIDTH = 24+IDX_W and DEPTH.
  - Ports push/full/pop/empty/dout.

## Test plan
- Reset, then stream reset, then 48 bits encoding GRB 0xFF0000 and 0x00FF80, with pix_ready=1. Expect pixels rgb=0x00FF00 idx=0 and rgb=0xFF0080 idx=1. A following stream reset gives frame_done with frame_len=2 and frame_partial=0.
- 24 bits sent before any stream reset. Expect no pix_valid and synced=0. After a stream reset, synced=1.
- NUM_LEDS=4 with 6 pixels in the frame. Expect exactly 4 pops with idx 0..3 and frame_len=4.
- pix_ready=0 with FIFO_DEPTH+1 pixels sent. Expect overflow=1 and the first 4 pixels preserved in order. clr_overflow then returns overflow to 0.
- 30 bits followed by a stream reset. Expect one pixel, frame_len=1 and frame_partial=1. The next frame starts at idx 0.
- rst asserted while the FIFO holds 2 pixels. Expect pix_valid=0 immediately and synced=0.
